seg7_scan_ctrl: RTL and testbench
=================================

// Module: seg7_scan_ctrl
// PURPOSE
//  Time-multiplexed scan controller for an NUM_DIGITS-digit common-anode 7-segment display.
//  Shares one external segment7 BCD decoder across all digits:
//    - drives the decoder bcd input one digit at a time;
//    - gates the decoded segments with an anti-ghosting blank interval;
//    - drives the digit anodes.
//  Host writes are double-buffered and take effect only at frame boundaries (no tearing).
// PARAMETERS
//  NUM_DIGITS    4          number of digits scanned (>=2)
//  REFRESH_DIV   50000      clk cycles per digit slot (>=2)
//  BLANK_CYCLES  16         leading cycles of each slot with all anodes off (<REFRESH_DIV)
//  SEG_OFF       7'h7F      segment pattern driven while blanked/suppressed (active-low segs)
// PORTS
//  clk          in   1              system clock, rising edge
//  rst          in   1              asynchronous reset, active-high
//  load         in   1              1-cycle strobe: capture value into shadow register
//  value        in   4*NUM_DIGITS   BCD digits, digit k = value[4k+3:4k], digit 0 = LSD
//  lz_suppress  in   1              1 = blank leading zeros (digit 0 never blanked)
//  seg_in       in   7              segment pattern returned by the segment7 decoder
//  bcd          out  4              digit code sent to the segment7 decoder (registered)
//  seg          out  7              segment drive to the display
//  an           out  NUM_DIGITS     digit anodes, active-low (registered)
//  frame_done   out  1              1-cycle pulse at each frame boundary (registered)
// BEHAVIOUR
//  Reset (async, rst=1): slot_cnt=0, idx=0, active=0, shadow=0, pending=0,
//    an=all 1, bcd=0, frame_done=0; seg=SEG_OFF while in blank phase.
//  Slot counter: slot_cnt counts 0..REFRESH_DIV-1.
//    At REFRESH_DIV-1: slot_cnt->0 and idx advances; idx wraps NUM_DIGITS-1 -> 0.
//  Phases within a slot:
//    - BLANK (slot_cnt < BLANK_CYCLES): an=all 1.
//    - DRIVE (otherwise): an has only bit idx low.
//    - an is registered: reflects the phase of the current slot_cnt value, updated on the same edge.
//  bcd = active digit idx, updated on the edge that starts the slot, held for the whole slot
//    so the combinational decoder settles during BLANK.
//  seg (combinational) = seg_in when DRIVE and digit idx is not suppressed; else SEG_OFF.
//  Leading-zero suppression: digit i is suppressed when lz_suppress=1, i>0, and every
//    active digit j in [i, NUM_DIGITS-1] equals 0. Evaluated on active (not shadow) data.
//  Codes 10..15 are passed to the decoder unmodified; they count as non-zero for suppression.
//  Load and commit:
//    - load=1: shadow<=value, pending<=1. Multiple loads in one frame: last wins.
//    - Frame boundary = edge where idx wraps NUM_DIGITS-1 -> 0. On it:
//      if pending, active<=shadow and pending<=0; frame_done=1 for exactly that following cycle.
//    - load on the boundary edge: commit uses the pre-edge shadow/pending; the new value
//      sets pending and is committed at the next boundary.
//  Timing: frame period = NUM_DIGITS*REFRESH_DIV cycles.
//    Worst-case load-to-display latency < 2 frames.
//  lz_suppress is sampled live (no double buffering).
//  Reset mid-slot: an goes all-1 immediately (async); scan restarts at digit 0, slot_cnt 0.
//    Any pending load is discarded.
// TESTING  (bench: NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2; include segment7 as decoder)
//  1 Reset asserted -> an=4'b1111, bcd=0, frame_done=0, seg=7'h7F; hold 3 cycles, no change.
//  2 load value=16'h1234, wait one boundary -> per slot bcd=4,3,2,1;
//    an=1110,1101,1011,0111 on slot cycles 2..7 and 1111 on cycles 0..1; frame_done every 32 cycles.
//  3 lz_suppress=1, value=16'h0045 -> seg=SEG_OFF in slots 3,2, decoded 4/5 in slots 1,0;
//    value=16'h0000 -> only slot 0 shows decoded '0'.
//  4 load 16'h1111 then 16'h2222 mid-frame -> display unchanged until boundary,
//    then shows 2222 (1111 never appears).
//  5 load 16'h9999 on frame_done edge -> current frame keeps old value;
//    9999 appears after the following boundary.
//  6 rst pulsed at slot cycle 5 of digit 2 -> an=1111 within same cycle, active=0,
//    pending cleared; scan resumes at digit 0.

Source files
------------

// File: rtl/seg7_scan_ctrl.sv
// rtl/seg7_scan_ctrl.sv - time-multiplexed 7-segment scan controller with double-buffered digits
module seg7_scan_ctrl #(
    parameter int          NUM_DIGITS   = 4,
    parameter int          REFRESH_DIV  = 50000,
    parameter int          BLANK_CYCLES = 16,
    parameter logic [6:0]  SEG_OFF      = 7'h7F
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    lz_suppress,
    input  logic [6:0]              seg_in,
    output logic [3:0]              bcd,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [CW-1:0]             slot_cnt;
    logic [CW-1:0]             slot_cnt_nxt;
    logic [IW-1:0]             idx;
    logic [IW-1:0]             idx_nxt;
    logic [4*NUM_DIGITS-1:0]   active;
    logic [4*NUM_DIGITS-1:0]   active_nxt;
    logic [4*NUM_DIGITS-1:0]   shadow;
    logic                      pending;
    logic                      slot_end;
    logic                      wrap;
    logic [NUM_DIGITS-1:0]     an_nxt;
    logic [3:0]                bcd_nxt;
    logic [NUM_DIGITS-1:0]     all_zero_above;
    logic                      digit_sup;
    logic                      drive;

    // Next scan position, the data that becomes active at a frame boundary,
    // and the registered anode/bcd values that match that next position.
    always_comb begin
        slot_end     = (slot_cnt == CW'(REFRESH_DIV - 1));
        wrap         = slot_end && (idx == IW'(NUM_DIGITS - 1));
        slot_cnt_nxt = slot_end ? '0 : slot_cnt + 1'b1;
        if (wrap)
            idx_nxt = '0;
        else if (slot_end)
            idx_nxt = idx + 1'b1;
        else
            idx_nxt = idx;
        active_nxt = (wrap && pending) ? shadow : active;
        an_nxt     = '1;
        bcd_nxt    = 4'd0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_nxt == IW'(k)) begin
                bcd_nxt = active_nxt[4*k +: 4];
                if (slot_cnt_nxt >= CW'(BLANK_CYCLES))
                    an_nxt[k] = 1'b0;
            end
        end
    end

    // Scan counters, anode and decoder-code registers; bcd only moves at slot start
    // so the external decoder has the whole blank phase to settle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_cnt   <= '0;
            idx        <= '0;
            an         <= '1;
            bcd        <= 4'd0;
            frame_done <= 1'b0;
        end else begin
            slot_cnt   <= slot_cnt_nxt;
            idx        <= idx_nxt;
            an         <= an_nxt;
            frame_done <= wrap;
            if (slot_end)
                bcd <= bcd_nxt;
        end
    end

    // Host double buffer: shadow captures every load, active only changes at a
    // frame boundary so a frame never shows a mix of old and new digits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow  <= '0;
            pending <= 1'b0;
            active  <= '0;
        end else begin
            active <= active_nxt;
            if (load) begin
                shadow  <= value;
                pending <= 1'b1;
            end else if (wrap) begin
                pending <= 1'b0;
            end
        end
    end

    // Leading-zero detection on active data: digit i is blankable when it and
    // every more significant digit are zero; digit 0 is always shown.
    always_comb begin
        all_zero_above = '0;
        all_zero_above[NUM_DIGITS-1] = (active[4*NUM_DIGITS-1 -: 4] == 4'd0);
        for (int i = NUM_DIGITS - 2; i >= 0; i--)
            all_zero_above[i] = all_zero_above[i+1] && (active[4*i +: 4] == 4'd0);
        digit_sup = 1'b0;
        for (int i = 1; i < NUM_DIGITS; i++)
            if (idx == IW'(i))
                digit_sup = lz_suppress && all_zero_above[i];
    end

    // Segment gating: decoder output only during the drive phase of a shown digit.
    always_comb begin
        drive = (slot_cnt >= CW'(BLANK_CYCLES));
        seg   = (drive && !digit_sup) ? seg_in : SEG_OFF;
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb/tb_seg7_scan_ctrl.sv - self-checking bench for seg7_scan_ctrl
module tb_seg7_scan_ctrl;

    localparam int ND    = 4;
    localparam int RD    = 8;
    localparam int BC    = 2;
    localparam int FRAME = ND * RD;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        load = 1'b0;
    logic        lz = 1'b0;
    logic [15:0] value = 16'h0;
    logic [6:0]  seg_in;
    logic [6:0]  seg;
    logic [3:0]  bcd;
    logic [3:0]  an;
    logic        frame_done;

    seg7_scan_ctrl #(
        .NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLANK_CYCLES(BC), .SEG_OFF(7'h7F)
    ) dut (
        .clk(clk), .rst(rst), .load(load), .value(value), .lz_suppress(lz),
        .seg_in(seg_in), .bcd(bcd), .seg(seg), .an(an), .frame_done(frame_done)
    );

    initial forever #5 clk = ~clk;

    function automatic logic [6:0] dec7(input logic [3:0] d);
        case (d)
            4'h0: dec7 = 7'h40; 4'h1: dec7 = 7'h79; 4'h2: dec7 = 7'h24; 4'h3: dec7 = 7'h30;
            4'h4: dec7 = 7'h19; 4'h5: dec7 = 7'h12; 4'h6: dec7 = 7'h02; 4'h7: dec7 = 7'h78;
            4'h8: dec7 = 7'h00; 4'h9: dec7 = 7'h10; 4'hA: dec7 = 7'h08; 4'hB: dec7 = 7'h03;
            4'hC: dec7 = 7'h46; 4'hD: dec7 = 7'h21; 4'hE: dec7 = 7'h06; default: dec7 = 7'h0E;
        endcase
    endfunction

    assign seg_in = dec7(bcd);

    typedef struct { int e; logic [15:0] v; } ld_t;
    ld_t loads[$];

    typedef struct {
        logic [15:0]      v;
        logic             lz;
        logic [3:0][6:0]  exp;
    } vec_t;
    vec_t tbl[7];

    int t;
    int checks = 0;
    int errors = 0;

    // Displayed data at time tt: a load sampled on edge e becomes visible at the
    // first frame boundary strictly after e; the latest such load wins.
    function automatic logic [15:0] model_active(input int tt);
        logic [15:0] a = 16'h0;
        foreach (loads[i])
            if ((loads[i].e / FRAME + 1) * FRAME <= tt)
                a = loads[i].v;
        return a;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0d got %0h expected %0h", name, t, act, exp);
        end
    endtask

    task automatic check_model();
        int          cnt  = t % RD;
        int          slot = (t / RD) % ND;
        logic [15:0] a    = model_active(t);
        logic [3:0]  d    = a[4*slot +: 4];
        logic        sup  = lz && (slot > 0) && ((a >> (4 * slot)) == 16'h0);
        logic [3:0]  ean  = (cnt < BC) ? 4'hF : ~(4'b0001 << slot);
        logic [6:0]  eseg = (cnt >= BC && !sup) ? dec7(d) : 7'h7F;
        chk("an", an, ean);
        chk("bcd", bcd, d);
        chk("frame_done", frame_done, (t > 0 && t % FRAME == 0));
        chk("seg", seg, eseg);
    endtask

    task automatic tick();
        if (load)
            loads.push_back('{t + 1, value});
        @(posedge clk);
        t++;
        @(negedge clk);
        check_model();
    endtask

    task automatic run_to(input int phase);
        while (t % FRAME != phase)
            tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_an", an, 4'hF);
        chk("rst_bcd", bcd, 4'h0);
        chk("rst_fd", frame_done, 1'b0);
        chk("rst_seg", seg, 7'h7F);
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            chk("rst_hold_an", an, 4'hF);
            chk("rst_hold_bcd", bcd, 4'h0);
            chk("rst_hold_fd", frame_done, 1'b0);
        end
        rst = 1'b0;
        load = 1'b0;
        t = 0;
        loads.delete();
        check_model();
    endtask

    initial begin
        tbl[0] = '{16'h1234, 1'b0, {7'h79, 7'h24, 7'h30, 7'h19}};
        tbl[1] = '{16'h0045, 1'b1, {7'h7F, 7'h7F, 7'h19, 7'h12}};
        tbl[2] = '{16'h0000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}};
        tbl[3] = '{16'h0000, 1'b0, {7'h40, 7'h40, 7'h40, 7'h40}};
        tbl[4] = '{16'h0A00, 1'b1, {7'h7F, 7'h08, 7'h40, 7'h40}};
        tbl[5] = '{16'h1004, 1'b1, {7'h79, 7'h40, 7'h40, 7'h19}};
        tbl[6] = '{16'h5678, 1'b0, {7'h12, 7'h02, 7'h78, 7'h00}};

        #2;
        do_reset();

        // Table: load, wait for commit, then check the decoded digit in every slot.
        foreach (tbl[r]) begin
            run_to(5);
            lz = tbl[r].lz;
            value = tbl[r].v;
            load = 1'b1;
            tick();
            load = 1'b0;
            run_to(0);
            chk("tbl_fd_pulse", frame_done, 1'b1);
            for (int c = 0; c < FRAME; c++) begin
                if (t % RD == BC + 2) begin
                    chk("tbl_seg", seg, tbl[r].exp[(t / RD) % ND]);
                    chk("tbl_bcd", bcd, tbl[r].v[4*((t / RD) % ND) +: 4]);
                end
                tick();
            end
        end
        lz = 1'b0;

        // Two loads mid-frame: old value until the boundary, then only the last one.
        run_to(5);
        value = 16'h1111; load = 1'b1; tick(); load = 1'b0;
        repeat (3) tick();
        value = 16'h2222; load = 1'b1; tick(); load = 1'b0;
        while (t % FRAME != 0) begin
            chk("t4_no_1111", (bcd != 4'h1), 1'b1);
            tick();
        end
        for (int c = 0; c < FRAME; c++) begin
            chk("t4_2222", bcd, 4'h2);
            tick();
        end

        // Load landing on the boundary edge waits one more frame.
        run_to(FRAME - 1);
        value = 16'h9999; load = 1'b1; tick(); load = 1'b0;
        chk("t5_fd", frame_done, 1'b1);
        for (int c = 0; c < FRAME; c++) begin
            chk("t5_old", bcd, 4'h2);
            tick();
        end
        for (int c = 0; c < FRAME; c++) begin
            chk("t5_9999", bcd, 4'h9);
            tick();
        end

        // Reset mid-slot with a load pending: blank at once, pending discarded.
        run_to(5);
        value = 16'h3333; load = 1'b1; tick(); load = 1'b0;
        run_to(2 * RD + 5);
        chk("t6_pre_an", an, 4'b1011);
        do_reset();
        for (int c = 0; c < 2 * FRAME + 4; c++) begin
            chk("t6_discard", bcd, 4'h0);
            tick();
        end

        // Randomized traffic against the model.
        for (int c = 0; c < 900; c++) begin
            if ($urandom_range(0, 63) == 0)
                lz = ~lz;
            if ($urandom_range(0, 11) == 0) begin
                logic [15:0] v = 16'($urandom);
                for (int k = 0; k < ND; k++)
                    if ($urandom_range(0, 1) == 0)
                        v[4*k +: 4] = 4'h0;
                value = v;
                load = 1'b1;
            end else begin
                load = 1'b0;
            end
            tick();
        end
        load = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout t=%0d got running expected finished", t);
        $fatal(1);
    end

endmodule
